// File: rtl/reg_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter_pkg
// Shared definitions for the round-robin register write arbiter:
//   - default requester count and data width
//   - arbiter FSM state encoding (ARB_LOCKED is only reachable when the
//     design is built with REG_ARB_LOCK_EN defined)
//   - small helper used by the FSM to classify states
// -----------------------------------------------------------------------------
package reg_write_arbiter_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

    // A state "owns" the register (drives a write) whenever it is not idle.
    function automatic logic state_writes(input arb_state_t s);
        return (s != ARB_IDLE);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_d_flipflop.sv
// -----------------------------------------------------------------------------
// d_flipflop
// Load-enabled storage register with no reset of its own; the owner clears it
// by loading zero.
// Ports:
//   clock  in   rising-edge clock
//   load   in   capture din on this edge when high, otherwise hold
//   din    in   WIDTH-bit data to capture
//   q      out  WIDTH-bit stored value
// -----------------------------------------------------------------------------
module d_flipflop #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    // Storage: capture on load, hold otherwise.
    always_ff @(posedge clock) begin
        if (load) begin
            q <= din;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/reg_write_arbiter_rr_grant_select.sv
// -----------------------------------------------------------------------------
// rr_grant_select
// Combinational round-robin pick: scans req_masked starting at ptr, upward,
// wrapping NUM_REQ-1 -> 0, and returns the first set bit.
// Ports:
//   req_masked  in   NUM_REQ request vector (already masked by the caller)
//   ptr         in   IDX_W   index where the search begins
//   valid       out  1       a requester was found
//   winner      out  IDX_W   index of the found requester (ptr when none)
// NUM_REQ must be a power of two so index arithmetic wraps naturally.
// -----------------------------------------------------------------------------
module rr_grant_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_masked,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    // Priority scan from the pointer; the first hit is kept, later hits ignored.
    always_comb begin
        valid  = 1'b0;
        winner = ptr;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!valid && req_masked[ptr + IDX_W'(off)]) begin
                valid  = 1'b1;
                winner = ptr + IDX_W'(off);
            end else begin
                valid  = valid;
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Round-robin write arbiter for one shared DATA_WIDTH register. One requester
// is granted per cycle; a granted requester's data is written into the shared
// d_flipflop during its grant cycle and becomes visible the cycle after.
// The currently granted requester is masked from the next decision, so a
// requester holding req alone is served every other cycle.
// Optional feature macro: REG_ARB_LOCK_EN adds the lock port and LOCKED state,
// letting a granted requester keep the register for consecutive writes.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-high; clears grant/pointer and loads 0
//   req      in   NUM_REQ level write requests
//   wdata    in   NUM_REQ*DATA_WIDTH, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   lock     in   NUM_REQ (REG_ARB_LOCK_EN only) hold grant while high
//   grant    out  NUM_REQ registered grant, one-hot or zero
//   busy     out  registered, high while grant is non-zero
//   reg_out  out  DATA_WIDTH shared register contents
//   last_id  out  IDX_W index of the last requester written
// -----------------------------------------------------------------------------
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            lock,
`endif
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         reg_out,
    output logic [IDX_W-1:0]              last_id
);

    arb_state_t              state_r;
    logic [NUM_REQ-1:0]      grant_r;
    logic                    busy_r;
    logic [IDX_W-1:0]        last_id_r;
    logic [IDX_W-1:0]        ptr_r;
    logic [IDX_W-1:0]        gidx_r;

    logic [NUM_REQ-1:0]      req_masked_s;
    logic                    sel_valid_s;
    logic [IDX_W-1:0]        sel_idx_s;
    logic                    lock_hold_s;
    logic                    load_s;
    logic [DATA_WIDTH-1:0]   din_s;

    // Request masking, lock detection and the register write path.
    always_comb begin
        req_masked_s = req & ~grant_r;
`ifdef REG_ARB_LOCK_EN
        lock_hold_s  = state_writes(state_r) && lock[gidx_r];
`else
        lock_hold_s  = 1'b0;
`endif
        // Reset clears the register by loading zero; the in-flight write is lost.
        if (reset) begin
            load_s = 1'b1;
            din_s  = {DATA_WIDTH{1'b0}};
        end else if (state_writes(state_r)) begin
            load_s = 1'b1;
            din_s  = wdata[int'(gidx_r) * DATA_WIDTH +: DATA_WIDTH];
        end else begin
            load_s = 1'b0;
            din_s  = {DATA_WIDTH{1'b0}};
        end
    end

    rr_grant_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_select (
        .req_masked (req_masked_s),
        .ptr        (ptr_r),
        .valid      (sel_valid_s),
        .winner     (sel_idx_s)
    );

    d_flipflop #(
        .WIDTH (DATA_WIDTH)
    ) u_storage (
        .clock (clock),
        .load  (load_s),
        .din   (din_s),
        .q     (reg_out)
    );

    // Arbiter FSM with registered grant/busy/last_id and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ARB_IDLE;
            grant_r   <= {NUM_REQ{1'b0}};
            busy_r    <= 1'b0;
            last_id_r <= {IDX_W{1'b0}};
            ptr_r     <= {IDX_W{1'b0}};
            gidx_r    <= {IDX_W{1'b0}};
        end else begin
            // last_id follows the write that lands on this edge.
            if (state_writes(state_r)) begin
                last_id_r <= gidx_r;
            end else begin
                last_id_r <= last_id_r;
            end

            if (lock_hold_s) begin
                // Locked owner keeps the grant; pointer already sits at owner+1.
                state_r <= ARB_LOCKED;
                grant_r <= grant_r;
                busy_r  <= 1'b1;
                ptr_r   <= ptr_r;
                gidx_r  <= gidx_r;
            end else if (sel_valid_s) begin
                state_r <= ARB_GRANT;
                grant_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
                busy_r  <= 1'b1;
                ptr_r   <= sel_idx_s + IDX_W'(1);
                gidx_r  <= sel_idx_s;
            end else begin
                state_r <= ARB_IDLE;
                grant_r <= {NUM_REQ{1'b0}};
                busy_r  <= 1'b0;
                ptr_r   <= ptr_r;
                gidx_r  <= gidx_r;
            end
        end
    end

    assign grant   = grant_r;
    assign busy    = busy_r;
    assign last_id = last_id_r;

endmodule
